// File: rtl/ef_smsdac_pkg.sv
// rtl/ef_smsdac_pkg.sv - shared mode, FSM and LFSR constants for the mismatch-shaping encoder control
package ef_smsdac_pkg;

    typedef enum logic [1:0] {
        MODE_STATIC = 2'b00,
        MODE_RANDOM = 2'b01,
        MODE_SHAPED = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic {
        ST_FLUSH = 1'b0,
        ST_RUN   = 1'b1
    } state_e;

    // x^16 + x^14 + x^13 + x^11 + 1
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

endpackage

// File: rtl/ef_smsdac_lfsr.sv
// rtl/ef_smsdac_lfsr.sv - free-running Fibonacci LFSR with all-zero lock-up guard
module ef_smsdac_lfsr
    import ef_smsdac_pkg::*;
#(
    parameter int             W     = 16,
    parameter logic [W-1:0]   SEED  = 16'hACE1,
    parameter int             OUT_W = 7
) (
    input  logic             clk,
    input  logic             rst,
    output logic [OUT_W-1:0] rnd
);

    localparam logic [W-1:0] TAPS = W'(LFSR_TAPS);

    logic [W-1:0] lfsr_q;
    logic [W-1:0] lfsr_d;

    // A zero state would stick forever, so it is replaced by the seed.
    always_comb begin
        lfsr_d = {lfsr_q[W-2:0], ^(lfsr_q & TAPS)};
        if (lfsr_q == '0) begin
            lfsr_d = SEED;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign rnd = lfsr_q[OUT_W-1:0];

endmodule

// File: rtl/ef_smsdac_mse_ctrl.sv
// rtl/ef_smsdac_mse_ctrl.sv - mode controller and random-bit scheduler for the segmented mismatch-shaping encoder
module ef_smsdac_mse_ctrl
    import ef_smsdac_pkg::*;
#(
    parameter int                N_SB      = 7,
    parameter int                LFSR_W    = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = 16'hACE1,
    parameter int                FLUSH_CYC = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            sample_tick,
    input  logic [1:0]      mode_req,
    input  logic            mode_load,
    output logic [N_SB-1:0] r_out,
    output logic [N_SB-1:0] en_out,
    output logic            sb_rst_b,
    output logic [1:0]      mode_cur,
    output logic            busy
);

    localparam int               CNT_W    = $clog2(FLUSH_CYC);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(FLUSH_CYC - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mode_e             mode_q, mode_d;
    mode_e             pend_q, pend_d;
    logic              pend_vld_q, pend_vld_d;
    logic [N_SB-1:0]   r_q, r_d;
    logic [N_SB-1:0]   en_q, en_d;
    logic              sb_rst_b_q, sb_rst_b_d;
    logic [N_SB-1:0]   lfsr_bits;
    logic              apply;
    mode_e             req_mode;

    ef_smsdac_lfsr #(
        .W     (LFSR_W),
        .SEED  (LFSR_SEED),
        .OUT_W (N_SB)
    ) u_lfsr (
        .clk (clk),
        .rst (rst),
        .rnd (lfsr_bits)
    );

    assign req_mode = mode_e'(mode_req);
    assign apply    = (state_q == ST_RUN) && sample_tick && pend_vld_q;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        mode_d     = mode_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        r_d        = r_q;

        case (state_q)
            ST_FLUSH: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_RUN: begin
                if (apply) begin
                    mode_d     = pend_q;
                    pend_vld_d = 1'b0;
                    // Shaping must start from a cleared tree state.
                    if (pend_q == MODE_SHAPED && mode_q != MODE_SHAPED) begin
                        state_d = ST_FLUSH;
                        cnt_d   = CNT_INIT;
                    end
                end
            end
            default: begin
                state_d = ST_FLUSH;
                cnt_d   = CNT_INIT;
            end
        endcase

        // A load coincident with an applying tick becomes the next pending request.
        if (mode_load && req_mode != MODE_RSVD) begin
            pend_d     = req_mode;
            pend_vld_d = 1'b1;
        end

        if (state_d == ST_FLUSH) begin
            r_d = '0;
        end else if (state_q == ST_RUN && sample_tick) begin
            r_d = (mode_d != MODE_STATIC) ? lfsr_bits : '0;
        end

        en_d       = (state_d == ST_RUN && mode_d == MODE_SHAPED) ? '1 : '0;
        sb_rst_b_d = (state_d == ST_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_FLUSH;
            cnt_q      <= CNT_INIT;
            mode_q     <= MODE_STATIC;
            pend_q     <= MODE_STATIC;
            pend_vld_q <= 1'b0;
            r_q        <= '0;
            en_q       <= '0;
            sb_rst_b_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            r_q        <= r_d;
            en_q       <= en_d;
            sb_rst_b_q <= sb_rst_b_d;
        end
    end

    assign r_out    = r_q;
    assign en_out   = en_q;
    assign sb_rst_b = sb_rst_b_q;
    assign mode_cur = mode_q;
    assign busy     = (state_q == ST_FLUSH) || pend_vld_q;

endmodule

// File: tb/tb_ef_smsdac_mse_ctrl.sv
// tb/tb_ef_smsdac_mse_ctrl.sv - directed self-checking bench for ef_smsdac_mse_ctrl
module tb_ef_smsdac_mse_ctrl;

    logic       clk;
    logic       rst;
    logic       sample_tick;
    logic [1:0] mode_req;
    logic       mode_load;
    logic [6:0] r_out;
    logic [6:0] en_out;
    logic       sb_rst_b;
    logic [1:0] mode_cur;
    logic       busy;

    int n_assert = 0;
    int n_fail   = 0;

    logic [15:0] lfsr_m;
    logic [15:0] samp;

    ef_smsdac_mse_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .sample_tick (sample_tick),
        .mode_req    (mode_req),
        .mode_load   (mode_load),
        .r_out       (r_out),
        .en_out      (en_out),
        .sb_rst_b    (sb_rst_b),
        .mode_cur    (mode_cur),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference LFSR: x^16+x^14+x^13+x^11+1, shift left, feedback into bit 0
    always @(posedge clk or posedge rst) begin
        if (rst) lfsr_m <= 16'hACE1;
        else if (lfsr_m == 16'h0) lfsr_m <= 16'hACE1;
        else lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
    end

    task automatic do_load(input logic [1:0] m);
        mode_req  = m;
        mode_load = 1'b1;
        @(negedge clk);
        mode_load = 1'b0;
    endtask

    task automatic do_tick(output logic [15:0] s);
        s = lfsr_m;
        sample_tick = 1'b1;
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic measure_flush(input string nm);
        int n = 0;
        while (sb_rst_b === 1'b0 && n < 20) begin
            n++;
            n_assert++;
            if (busy !== 1'b1 || en_out !== 7'h0 || r_out !== 7'h0) begin
                n_fail++;
                $display("FAIL %s_flush_outputs: busy=%b en_out=%h r_out=%h, required busy=1 en_out=00 r_out=00", nm, busy, en_out, r_out);
            end
            @(negedge clk);
        end
        n_assert++;
        if (n !== 4) begin
            n_fail++;
            $display("FAIL %s_flush_len: sb_rst_b low %0d cycles, required 4", nm, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; sample_tick = 1'b0; mode_load = 1'b0; mode_req = 2'b00;
        repeat (3) @(negedge clk);
        n_assert++;
        if ({r_out, en_out, sb_rst_b, mode_cur, busy} !== {7'h0, 7'h0, 1'b0, 2'b00, 1'b1}) begin
            n_fail++;
            $display("FAIL reset_values: r=%h en=%h sb=%b mode=%b busy=%b, required 00 00 0 00 1", r_out, en_out, sb_rst_b, mode_cur, busy);
        end
        rst = 1'b0;
        measure_flush("reset");
        n_assert++;
        if ({sb_rst_b, busy, mode_cur, en_out, r_out} !== {1'b1, 1'b0, 2'b00, 7'h0, 7'h0}) begin
            n_fail++;
            $display("FAIL reset_run: sb=%b busy=%b mode=%b en=%h r=%h, required 1 0 00 00 00", sb_rst_b, busy, mode_cur, en_out, r_out);
        end
    endtask

    task automatic test_static_to_random();
        logic [15:0] s;
        do_load(2'b01);
        n_assert++;
        if (busy !== 1'b1 || mode_cur !== 2'b00) begin
            n_fail++;
            $display("FAIL s2r_pending: busy=%b mode=%b, required 1 00", busy, mode_cur);
        end
        do_tick(s);
        n_assert++;
        if ({mode_cur, sb_rst_b, en_out, busy} !== {2'b01, 1'b1, 7'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL s2r_apply: mode=%b sb=%b en=%h busy=%b, required 01 1 00 0", mode_cur, sb_rst_b, en_out, busy);
        end
        repeat (2) @(negedge clk);
        do_tick(s);
        n_assert++;
        if (r_out !== s[6:0]) begin
            n_fail++;
            $display("FAIL s2r_r_out: r_out=%h, required %h", r_out, s[6:0]);
        end
        repeat (3) @(negedge clk);
        n_assert++;
        if (r_out !== s[6:0] || en_out !== 7'h0) begin
            n_fail++;
            $display("FAIL s2r_hold: r_out=%h en=%h, required %h 00", r_out, en_out, s[6:0]);
        end
    endtask

    task automatic test_random_to_shaped();
        logic [15:0] s;
        do_load(2'b10);
        do_tick(s);
        n_assert++;
        if (mode_cur !== 2'b10 || sb_rst_b !== 1'b0) begin
            n_fail++;
            $display("FAIL r2s_apply: mode=%b sb=%b, required 10 0", mode_cur, sb_rst_b);
        end
        measure_flush("r2s");
        n_assert++;
        if ({en_out, busy, mode_cur} !== {7'h7F, 1'b0, 2'b10}) begin
            n_fail++;
            $display("FAIL r2s_run: en=%h busy=%b mode=%b, required 7f 0 10", en_out, busy, mode_cur);
        end
        do_tick(s);
        n_assert++;
        if (r_out !== s[6:0] || en_out !== 7'h7F) begin
            n_fail++;
            $display("FAIL r2s_r_out: r_out=%h en=%h, required %h 7f", r_out, en_out, s[6:0]);
        end
    endtask

    task automatic test_dup_shaped();
        logic [15:0] s;
        do_load(2'b10);
        n_assert++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL dup_shaped_pending: busy=%b, required 1", busy);
        end
        do_tick(s);
        n_assert++;
        if ({sb_rst_b, busy, en_out, mode_cur} !== {1'b1, 1'b0, 7'h7F, 2'b10}) begin
            n_fail++;
            $display("FAIL dup_shaped_noflush: sb=%b busy=%b en=%h mode=%b, required 1 0 7f 10", sb_rst_b, busy, en_out, mode_cur);
        end
    endtask

    task automatic test_simultaneous();
        logic [15:0] s;
        int n;
        do_load(2'b01);
        mode_req = 2'b10; mode_load = 1'b1; sample_tick = 1'b1;
        @(negedge clk);
        mode_load = 1'b0; sample_tick = 1'b0;
        n_assert++;
        if ({mode_cur, busy, en_out, sb_rst_b} !== {2'b01, 1'b1, 7'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL simul_old: mode=%b busy=%b en=%h sb=%b, required 01 1 00 1", mode_cur, busy, en_out, sb_rst_b);
        end
        do_tick(s);
        n_assert++;
        if (mode_cur !== 2'b10 || sb_rst_b !== 1'b0) begin
            n_fail++;
            $display("FAIL simul_new: mode=%b sb=%b, required 10 0", mode_cur, sb_rst_b);
        end
        do_load(2'b00);
        do_tick(s);
        n_assert++;
        if ({mode_cur, busy, sb_rst_b} !== {2'b10, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_tick_ignored: mode=%b busy=%b sb=%b, required 10 1 0", mode_cur, busy, sb_rst_b);
        end
        n = 0;
        while (sb_rst_b !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        n_assert++;
        if (busy !== 1'b1 || en_out !== 7'h7F || n >= 20) begin
            n_fail++;
            $display("FAIL flush_pending_kept: busy=%b en=%h wait=%0d, required 1 7f <20", busy, en_out, n);
        end
        do_tick(s);
        n_assert++;
        if ({mode_cur, en_out, r_out, busy} !== {2'b00, 7'h0, 7'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL flush_pending_apply: mode=%b en=%h r=%h busy=%b, required 00 00 00 0", mode_cur, en_out, r_out, busy);
        end
    endtask

    task automatic test_reserved_dup();
        logic [15:0] s;
        do_load(2'b11);
        n_assert++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rsvd_dropped: busy=%b, required 0", busy);
        end
        do_tick(s);
        n_assert++;
        if (mode_cur !== 2'b00) begin
            n_fail++;
            $display("FAIL rsvd_no_apply: mode=%b, required 00", mode_cur);
        end
        do_load(2'b01);
        do_load(2'b11);
        n_assert++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rsvd_keeps_pending: busy=%b, required 1", busy);
        end
        do_tick(s);
        n_assert++;
        if (mode_cur !== 2'b01 || r_out !== s[6:0]) begin
            n_fail++;
            $display("FAIL rsvd_old_applied: mode=%b r=%h, required 01 %h", mode_cur, r_out, s[6:0]);
        end
        do_load(2'b01);
        do_tick(s);
        n_assert++;
        if ({mode_cur, busy, sb_rst_b, en_out} !== {2'b01, 1'b0, 1'b1, 7'h0}) begin
            n_fail++;
            $display("FAIL dup_random: mode=%b busy=%b sb=%b en=%h, required 01 0 1 00", mode_cur, busy, sb_rst_b, en_out);
        end
    endtask

    task automatic test_random_to_static();
        logic [15:0] s;
        do_load(2'b00);
        do_tick(s);
        n_assert++;
        if (mode_cur !== 2'b00 || r_out !== 7'h0) begin
            n_fail++;
            $display("FAIL r2static: mode=%b r=%h, required 00 00", mode_cur, r_out);
        end
    endtask

    task automatic test_lfsr_guard();
        force dut.u_lfsr.lfsr_q = 16'h0;
        #1;
        release dut.u_lfsr.lfsr_q;
        @(posedge clk);
        #1;
        n_assert++;
        if (dut.u_lfsr.lfsr_q !== 16'hACE1) begin
            n_fail++;
            $display("FAIL lfsr_guard: lfsr=%h, required ace1", dut.u_lfsr.lfsr_q);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_flush();
        logic [15:0] s;
        do_load(2'b10);
        do_tick(s);
        @(negedge clk);
        do_load(2'b01);
        rst = 1'b1;
        #1;
        n_assert++;
        if ({mode_cur, busy, sb_rst_b, en_out, r_out} !== {2'b00, 1'b1, 1'b0, 7'h0, 7'h0}) begin
            n_fail++;
            $display("FAIL async_reset: mode=%b busy=%b sb=%b en=%h r=%h, required 00 1 0 00 00", mode_cur, busy, sb_rst_b, en_out, r_out);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        measure_flush("rst_mid");
        n_assert++;
        if (busy !== 1'b0 || mode_cur !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_pending_discard: busy=%b mode=%b, required 0 00", busy, mode_cur);
        end
    endtask

    initial begin
        rst = 1'b1; sample_tick = 1'b0; mode_load = 1'b0; mode_req = 2'b00;
        test_reset();
        test_static_to_random();
        test_random_to_shaped();
        test_dup_shaped();
        test_simultaneous();
        test_reserved_dup();
        test_random_to_static();
        test_lfsr_guard();
        test_reset_mid_flush();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
